uart_tx_mmio: RTL

Memory-mapped UART transmitter on the CPU data-store bus, beside `dmem`. It watches the same `MemWrite` / `DataAdr` / `WriteData` strobes that `dmem` receives, captures stores to its own address window into a small TX FIFO, and serialises each byte as an 8N1 frame on `tx`. It returns a status word for loads in its window; top-level logic muxes `rd` over `dmem` data when `sel` is high.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_mmio_fifo.sv | 65 ++++++
 rtl/uart_tx_mmio.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
// Imported by the TX FIFO and the transmitter top level.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic [2:0] UART_TXDATA = 3'd0;
    localparam logic [2:0] UART_STATUS = 3'd4;

    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_ACTIVE = 2;
    localparam int ST_OVF    = 3;

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// Synchronous first-word-fall-through FIFO used as the UART TX queue.
// Pushes when full and pops when empty are ignored.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// UART 8N1 transmitter snooping the data-store bus, with a TX FIFO
// and a STATUS register readable at offset 4 of its window.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        sel,
    output logic        tx,
    output logic        busy
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_state_t   state;
    uart_state_t   state_n;
    logic [7:0]    shift;
    logic [7:0]    shift_n;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_cnt_n;
    logic [BW-1:0] baud;
    logic [BW-1:0] baud_n;
    logic          baud_end;
    logic          tx_q;
    logic          tx_n;
    logic          ovf;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;

    logic [2:0]    offset;
    logic          wr_data;
    logic          wr_status;
    logic          unused;

    assign sel       = (a[31:3] == BASE_ADDR[31:3]);
    assign offset    = a[2:0];
    assign wr_data   = we && sel && (offset == UART_TXDATA);
    assign wr_status = we && sel && (offset == UART_STATUS);
    assign fifo_push = wr_data;
    assign baud_end  = (baud == BAUD_LAST);
    assign tx        = tx_q;
    assign busy      = (state != IDLE) || !fifo_empty;
    assign unused    = ^{wd[31:8], fifo_count};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (wd[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Next-state logic: frame sequencing, FIFO pop and next line level.
    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bit_cnt_n = bit_cnt;
        baud_n    = baud;
        fifo_pop  = 1'b0;
        tx_n      = 1'b1;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_n   = fifo_dout;
                    bit_cnt_n = 3'd0;
                    baud_n    = '0;
                    state_n   = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_n  = '0;
                    state_n = DATA;
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_n    = '0;
                    shift_n   = {1'b0, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = STOP;
                    end
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_n = '0;
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shift_n   = fifo_dout;
                        bit_cnt_n = 3'd0;
                        state_n   = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    // Transmitter state, counters and the glitch-free line flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            baud    <= '0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            bit_cnt <= bit_cnt_n;
            baud    <= baud_n;
            tx_q    <= tx_n;
        end
    end

    // Sticky overflow: set by a dropped push, cleared by STATUS bit 3.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (wr_data && fifo_full) begin
            ovf <= 1'b1;
        end else if (wr_status && wd[ST_OVF]) begin
            ovf <= 1'b0;
        end
    end

    // Load data: STATUS at offset 4, zero elsewhere and outside the window.
    always_comb begin
        rd = '0;
        if (sel && (offset == UART_STATUS)) begin
            rd[ST_FULL]   = fifo_full;
            rd[ST_EMPTY]  = fifo_empty;
            rd[ST_ACTIVE] = (state != IDLE);
            rd[ST_OVF]    = ovf;
        end
    end

endmodule
